// File: rtl/instr_fetch.sv
// instr_fetch: program counter, single-outstanding instruction-memory read,
// and a holding register that presents the fetched word to decode.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | one quiet cycle out of reset before the first request
// REQ   | request valid at PC, waiting for the memory to accept it
// WAIT  | request accepted, waiting for the read response
// VALID | instr/instr_addr presented, waiting for downstream handshake
// FAULT | misaligned next_pc seen, fetch halted until reset
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] next_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_addr,
  input  logic        instr_ready,
  output logic        fetch_fault,
  output logic [31:0] fault_addr,
  output logic [31:0] fetch_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    VALID = 3'd3,
    FAULT = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_addr_q, instr_addr_d;
  logic [31:0] fault_addr_q, fault_addr_d;
  logic [31:0] count_q, count_d;
  logic        req_valid_q, instr_valid_q, fault_q;

  // Next-state and datapath updates; handshake inputs only matter in their own state.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    instr_addr_d = instr_addr_q;
    fault_addr_d = fault_addr_q;
    count_d      = count_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (imem_resp_valid) begin
          instr_d      = imem_resp_data;
          instr_addr_d = pc_q;
          state_d      = VALID;
        end
      end
      VALID: begin
        if (instr_ready) begin
          count_d = count_q + 32'd1;
          if (next_pc[1:0] == 2'b00) begin
            pc_d    = next_pc;
            state_d = REQ;
          end else begin
            fault_addr_d = next_pc;
            state_d      = FAULT;
          end
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and output flags; flags are registered from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      instr_addr_q  <= 32'd0;
      fault_addr_q  <= 32'd0;
      count_q       <= 32'd0;
      req_valid_q   <= 1'b0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_addr_q  <= instr_addr_d;
      fault_addr_q  <= fault_addr_d;
      count_q       <= count_d;
      req_valid_q   <= (state_d == REQ);
      instr_valid_q <= (state_d == VALID);
      fault_q       <= (state_d == FAULT);
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign instr_valid    = instr_valid_q;
  assign instr          = instr_q;
  assign instr_addr     = instr_addr_q;
  assign fetch_fault    = fault_q;
  assign fault_addr     = fault_addr_q;
  assign fetch_count    = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: cycle table for the zero-wait stream, then hand
// sequences for stalls, late/spurious responses, faults and mid-WAIT reset.
module tb_instr_fetch;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] next_pc = 32'd0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'd0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_addr;
  logic        instr_ready = 1'b0;
  logic        fetch_fault;
  logic [31:0] fault_addr;
  logic [31:0] fetch_count;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RPC)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .next_pc        (next_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_addr     (instr_addr),
    .instr_ready    (instr_ready),
    .fetch_fault    (fetch_fault),
    .fault_addr     (fault_addr),
    .fetch_count    (fetch_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;
  txn_t sb_q[$];

  typedef struct {
    logic        rv;
    logic [31:0] ra;
    logic        iv;
    logic [31:0] cnt;
  } vec_t;
  vec_t tbl[10];

  logic [31:0] exp_count = 32'd0;
  int          mem_delay = 0;
  bit          mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'd0;
  bit          inj = 1'b0;
  logic [31:0] inj_data = 32'd0;
  bit          auto_next = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: score handshakes seen before the edge, then drive the memory model.
  task automatic step();
    bit   acc, hs;
    txn_t t;
    acc = reset_n && imem_req_valid && imem_req_ready;
    hs  = reset_n && instr_valid && instr_ready;
    if (hs) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_underflow: got handshake at %h expected no instruction", instr_addr);
      end else begin
        t = sb_q.pop_front();
        check("sb_instr", instr, t.data);
        check("sb_instr_addr", instr_addr, t.addr);
      end
      exp_count++;
    end
    if (acc) begin
      sb_q.push_back('{imem_req_addr, mem_word(imem_req_addr)});
      mem_pend = 1'b1;
      mem_cnt  = mem_delay;
      mem_addr = imem_req_addr;
    end
    @(posedge clk);
    #1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'd0;
    if (mem_pend) begin
      if (mem_cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(mem_addr);
        mem_pend        = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
    if (inj) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = inj_data;
      inj             = 1'b0;
    end
    if (auto_next) next_pc = instr_addr + 32'd4;
    @(negedge clk);
    if (hs) check("fetch_count", fetch_count, exp_count);
  endtask

  task automatic wait_valid(input string name, output int k);
    k = 0;
    while (!instr_valid && k < 20) begin
      step();
      k++;
    end
    check(name, 32'(instr_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    tbl[0] = '{1'b0, RPC,          1'b0, 32'd0};
    tbl[1] = '{1'b1, RPC,          1'b0, 32'd0};
    tbl[2] = '{1'b0, RPC,          1'b0, 32'd0};
    tbl[3] = '{1'b0, RPC,          1'b1, 32'd0};
    tbl[4] = '{1'b1, RPC + 32'd4,  1'b0, 32'd1};
    tbl[5] = '{1'b0, RPC + 32'd4,  1'b0, 32'd1};
    tbl[6] = '{1'b0, RPC + 32'd4,  1'b1, 32'd1};
    tbl[7] = '{1'b1, RPC + 32'd8,  1'b0, 32'd2};
    tbl[8] = '{1'b0, RPC + 32'd8,  1'b0, 32'd2};
    tbl[9] = '{1'b0, RPC + 32'd8,  1'b1, 32'd2};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_fault", 32'(fetch_fault), 32'd0);
    check("rst_count", fetch_count, 32'd0);
    check("rst_pc", imem_req_addr, RPC);
    check("rst_instr", instr, 32'd0);

    // Zero-wait stream, cycle by cycle
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    mem_delay      = 0;
    auto_next      = 1'b1;
    next_pc        = RPC + 32'd4;
    reset_n        = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check($sformatf("c%0d_req_valid", c), 32'(imem_req_valid), 32'(tbl[c].rv));
      check($sformatf("c%0d_req_addr", c), imem_req_addr, tbl[c].ra);
      check($sformatf("c%0d_instr_valid", c), 32'(instr_valid), 32'(tbl[c].iv));
      check($sformatf("c%0d_count", c), fetch_count, tbl[c].cnt);
      step();
    end
    check("stream_count3", fetch_count, 32'd3);

    // Request stall: memory not ready for 5 cycles
    auto_next      = 1'b0;
    imem_req_ready = 1'b0;
    instr_ready    = 1'b0;
    mem_delay      = 4;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_req_valid", 32'(imem_req_valid), 32'd1);
      check("stall_req_addr", imem_req_addr, 32'h0000_010C);
    end
    imem_req_ready = 1'b1;
    step();
    check("accept_req_valid", 32'(imem_req_valid), 32'd0);
    check("accept_instr_valid", 32'(instr_valid), 32'd0);

    // Delayed response, then spurious response while in VALID
    wait_valid("delay_valid", k);
    check("delay_cycles", 32'(k), 32'd5);
    check("delay_instr", instr, mem_word(32'h0000_010C));
    check("delay_instr_addr", instr_addr, 32'h0000_010C);
    inj      = 1'b1;
    inj_data = 32'hDEAD_BEEF;
    step();
    step();
    check("spur_instr", instr, mem_word(32'h0000_010C));
    check("spur_instr_valid", 32'(instr_valid), 32'd1);

    // Back-pressure with next_pc toggling
    for (int i = 0; i < 6; i++) begin
      next_pc = (i % 2 == 1) ? 32'h0000_0300 : 32'h0000_0404;
      step();
      check("bp_instr", instr, mem_word(32'h0000_010C));
      check("bp_instr_addr", instr_addr, 32'h0000_010C);
      check("bp_pc", imem_req_addr, 32'h0000_010C);
      check("bp_count", fetch_count, 32'd3);
    end
    next_pc     = 32'h0000_0200;
    instr_ready = 1'b1;
    step();
    check("bp_new_pc", imem_req_addr, 32'h0000_0200);
    check("bp_req_valid", 32'(imem_req_valid), 32'd1);
    instr_ready = 1'b0;
    mem_delay   = 0;
    next_pc     = 32'h0000_0999;
    wait_valid("fetch200_valid", k);
    check("fetch200_addr", instr_addr, 32'h0000_0200);

    // Misaligned next_pc -> sticky fault
    next_pc     = 32'h0000_0202;
    instr_ready = 1'b1;
    step();
    check("fault_flag", 32'(fetch_fault), 32'd1);
    check("fault_addr", fault_addr, 32'h0000_0202);
    for (int i = 0; i < 4; i++) begin
      next_pc = 32'h0000_0400;
      step();
      check("fault_hold", 32'(fetch_fault), 32'd1);
      check("fault_no_req", 32'(imem_req_valid), 32'd0);
      check("fault_no_instr", 32'(instr_valid), 32'd0);
      check("fault_pc", imem_req_addr, 32'h0000_0200);
    end

    // Reset clears fault
    reset_n = 1'b0;
    #1;
    check("rst2_fault", 32'(fetch_fault), 32'd0);
    check("rst2_fault_addr", fault_addr, 32'd0);
    check("rst2_count", fetch_count, 32'd0);
    check("rst2_pc", imem_req_addr, RPC);
    sb_q.delete();
    exp_count = 32'd0;
    mem_pend  = 1'b0;
    @(negedge clk);
    reset_n        = 1'b1;
    instr_ready    = 1'b0;
    imem_req_ready = 1'b1;
    mem_delay      = 3;
    step();
    check("rst2_req", 32'(imem_req_valid), 32'd1);
    step();
    check("mw_in_wait", 32'(imem_req_valid), 32'd0);

    // Reset mid-WAIT; the outstanding response arrives after restart
    reset_n = 1'b0;
    #1;
    check("mw_rst_instr", instr, 32'd0);
    check("mw_rst_instr_addr", instr_addr, 32'd0);
    sb_q.delete();
    imem_req_ready = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    step();
    step();
    check("late_req_valid", 32'(imem_req_valid), 32'd1);
    check("late_pc", imem_req_addr, RPC);
    check("late_instr", instr, 32'd0);
    check("late_instr_valid", 32'(instr_valid), 32'd0);
    check("late_count", fetch_count, 32'd0);
    imem_req_ready = 1'b1;
    instr_ready    = 1'b0;
    mem_delay      = 0;
    next_pc        = RPC + 32'd4;
    wait_valid("restart_valid", k);
    check("restart_addr", instr_addr, RPC);
    instr_ready = 1'b1;
    step();
    check("restart_count", fetch_count, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage: holds the program counter, issues one instruction-memory read at a time, and presents the fetched word with its address to decode and branch resolution. The downstream next-PC mux computes `next_pc` combinationally from the presented `instr`/`instr_addr`; this block latches that value into the PC when the current instruction is consumed. Strictly in-order, one outstanding request, no speculation.

## Interface

- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

- `clk` in 1: single clock, all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `next_pc` in 32: next PC from the next-PC mux; sampled only on the instruction handshake edge.
- `imem_req_valid` out 1: read request valid.
- `imem_req_addr` out 32: read address, always equal to the PC register.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_resp_valid` in 1: read data valid.
- `imem_resp_data` in 32: read data.
- `instr_valid` out 1: `instr`/`instr_addr` hold a fetched instruction.
- `instr` out 32: fetched instruction word.
- `instr_addr` out 32: address of `instr`.
- `instr_ready` in 1: downstream consumes the instruction.
- `fetch_fault` out 1: sticky misaligned-PC fault.
- `fault_addr` out 32: offending `next_pc` value.
- `fetch_count` out 32: number of instructions consumed; wraps modulo 2^32.

## Operation

- States: IDLE, REQ, WAIT, VALID, FAULT.
- Reset (`reset_n` low, immediate): state=IDLE, PC=RESET_PC, `instr`=0, `instr_addr`=0, `fault_addr`=0, `fetch_count`=0. Outputs during reset: `imem_req_valid`=0, `instr_valid`=0, `fetch_fault`=0.
- IDLE: no outputs asserted. Unconditionally moves to REQ on the next edge.
- REQ: `imem_req_valid`=1, `imem_req_addr`=PC. On `imem_req_ready`=1, move to WAIT. Otherwise hold, with address stable.
- WAIT: `imem_req_valid`=0. On `imem_resp_valid`=1, capture `instr`←`imem_resp_data` and `instr_addr`←PC, then move to VALID.
- VALID: `instr_valid`=1, and `instr`/`instr_addr` are stable. On `instr_ready`=1 (handshake), increment `fetch_count` by 1, then:
  - if `next_pc[1:0]`==0: PC←`next_pc`, move to REQ;
  - otherwise: `fault_addr`←`next_pc`, move to FAULT.
- FAULT: `fetch_fault`=1, `imem_req_valid`=0, `instr_valid`=0. Terminal until reset.
- `imem_resp_valid` outside WAIT is ignored; it causes no state or data change.
- `instr_ready` outside VALID is ignored.
- `next_pc` is not sampled outside the VALID handshake edge.
- `imem_req_valid`, `instr_valid` and `fetch_fault` decode from state only. No output combinationally depends on `instr_ready`, `imem_req_ready` or `imem_resp_valid`.
- Arithmetic: `fetch_count` is a 32-bit unsigned increment; 32'hFFFF_FFFF+1 → 0. The PC is 32 bits, so `next_pc` values past 32'hFFFF_FFFC wrap naturally and are not treated as a fault.

## Timing

- Reset release at edge E0 → IDLE through the first cycle; REQ is visible after E1.
- Zero-wait memory (ready=1, response on the cycle after acceptance), downstream ready=1:
  - REQ, WAIT and VALID each last 1 cycle, giving 3 cycles per instruction.
  - First `instr_valid` appears 3 cycles after reset release.
- Request-to-data latency: response captured on the first edge in WAIT with `imem_resp_valid`=1. A response asserted in the same cycle as request acceptance is not honoured.
- `instr_valid` rises on the edge after response capture and falls on the edge after the handshake.
- Back-pressure: VALID holds indefinitely. The PC, `instr`, `instr_addr` and `fetch_count` remain unchanged while `instr_ready`=0.
- Reset asserted mid-WAIT: state immediately returns to IDLE. The memory shares `reset_n`; a late response after reset arrives outside WAIT and is dropped.

## Test plan

- Reset with RESET_PC=32'h0000_0100, zero-wait memory, ready=1, `next_pc`=`instr_addr`+4 → requests to 0x100, 0x104 and 0x108 on cycles 1, 4 and 7. `instr_valid` pulses on cycles 3, 6 and 9; `fetch_count`=3 after the third handshake.
- `imem_req_ready` held low 5 cycles in REQ → `imem_req_valid`=1 and `imem_req_addr` stable throughout; WAIT is entered only after ready.
- Response delayed 4 cycles, plus a spurious `imem_resp_valid` with data 0xDEADBEEF while in VALID → the spurious data never appears; `instr` holds the WAIT-captured word.
- `instr_ready`=0 for 6 cycles in VALID, with `next_pc` toggling → `instr`, `instr_addr` and PC unchanged; PC takes the `next_pc` present on the handshake edge (0x200).
- Handshake with `next_pc`=32'h0000_0202 → FAULT. `fetch_fault`=1, `fault_addr`=0x202, no further requests; only `reset_n` clears the fault.
- `reset_n` pulsed low mid-WAIT, memory response arrives 2 cycles later → the response is ignored; fetch restarts at RESET_PC with `fetch_count`=0.
